// File: rtl/branch_checker.sv
// branch_checker: tracks outstanding predicted conditional branches in a small
// FIFO and compares each against its resolved outcome. Result, flush and
// redirect_pc are registered (one cycle after res_valid). A miss flushes the
// whole queue, including any enqueue in the same cycle.
// Optional build macro: BRANCH_CHECKER_STATS_EN adds saturating br_total and
// br_miss counters as extra outputs.
module branch_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_alt_pc,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic [2:0]               result,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   outstanding
`ifdef BRANCH_CHECKER_STATS_EN
  ,
  output logic [31:0]              br_total,
  output logic [31:0]              br_miss
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ACTIVE,
    S_FULL
  } occ_e;

  // Entry storage; contents are only meaningful between rd and wr pointers,
  // so it carries no reset.
  logic            taken_mem [DEPTH];
  logic [PC_W-1:0] alt_mem   [DEPTH];

  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  occ_e            state_q,  state_d;
  logic [2:0]      result_q, result_d;
  logic            flush_q,  flush_d;
  logic [PC_W-1:0] redir_q,  redir_d;

  logic            enq;
  logic            pop;
  logic            hit;
  logic            miss;
  logic            head_taken;
  logic [PC_W-1:0] head_alt;

  // Handshake, head-of-queue compare and next-state computation.
  always_comb begin
    pred_ready = (count_q < CW'(DEPTH));
    enq        = pred_valid && pred_ready;
    pop        = res_valid && (state_q != S_EMPTY);
    head_taken = taken_mem[rd_ptr_q];
    head_alt   = alt_mem[rd_ptr_q];
    hit        = (head_taken == res_taken);
    miss       = pop && !hit;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    result_d   = 3'b000;
    flush_d    = 1'b0;
    redir_d    = redir_q;

    if (miss) begin
      // Drop everything younger, and the same-cycle enqueue, by collapsing
      // both pointers onto the slot after the mispredicted entry.
      rd_ptr_d = rd_ptr_q + AW'(1);
      wr_ptr_d = rd_ptr_q + AW'(1);
      count_d  = '0;
      flush_d  = 1'b1;
      redir_d  = head_alt;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(enq);
      count_d  = count_q + CW'(enq) - CW'(pop);
    end

    if (pop) begin
      result_d = {1'b1, res_taken, hit};
    end

    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = S_FULL;
    end else begin
      state_d = S_ACTIVE;
    end
  end

  // Queue control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_EMPTY;
      result_q <= '0;
      flush_q  <= 1'b0;
      redir_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      result_q <= result_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
    end
  end

  // Entry write; skipped on reset and on a flushing miss since the slot is discarded.
  always_ff @(posedge clk) begin
    if (rst && enq && !miss) begin
      taken_mem[wr_ptr_q] <= pred_taken;
      alt_mem[wr_ptr_q]   <= pred_alt_pc;
    end
  end

  assign result      = result_q;
  assign flush       = flush_q;
  assign redirect_pc = redir_q;
  assign outstanding = count_q;

`ifdef BRANCH_CHECKER_STATS_EN
  logic [31:0] br_total_q;
  logic [31:0] br_miss_q;

  // Saturating resolution and miss counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_total_q <= '0;
      br_miss_q  <= '0;
    end else if (pop) begin
      if (br_total_q != '1) begin
        br_total_q <= br_total_q + 32'd1;
      end
      if (miss && (br_miss_q != '1)) begin
        br_miss_q <= br_miss_q + 32'd1;
      end
    end
  end

  assign br_total = br_total_q;
  assign br_miss  = br_miss_q;
`endif

endmodule

// File: tb/tb_branch_checker.sv
// Directed scoreboard bench for branch_checker (DEPTH=4, PC_W=32).
// Stimulus pushes the hand-computed expected outputs for the next sample
// point; an independent monitor samples #1 after every rising edge and
// compares against the queued expectations tagged for that cycle.
module tb_branch_checker;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_alt_pc;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [2:0]  result;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  outstanding;
`ifdef BRANCH_CHECKER_STATS_EN
  logic [31:0] br_total;
  logic [31:0] br_miss;
`endif

  branch_checker #(.DEPTH(4), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_alt_pc (pred_alt_pc),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .result      (result),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .outstanding (outstanding)
`ifdef BRANCH_CHECKER_STATS_EN
    ,
    .br_total    (br_total),
    .br_miss     (br_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        chk_main;
    logic [2:0]  res;
    logic        fl;
    logic        chk_pc;
    logic [31:0] pc;
    int unsigned outst;
    logic        rdy;
    logic        chk_st;
    int unsigned tot;
    int unsigned mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned mon_cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, mon_cyc);
    end
  endtask

  // Monitor: sample just after each rising edge, compare due expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      while (sb.size() > 0 && sb[0].cyc <= mon_cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_main) begin
          check("result", 32'(result), 32'(e.res));
          check("flush", 32'(flush), 32'(e.fl));
          check("outstanding", 32'(outstanding), e.outst);
          check("pred_ready", 32'(pred_ready), 32'(e.rdy));
          if (e.chk_pc) check("redirect_pc", redirect_pc, e.pc);
        end
`ifdef BRANCH_CHECKER_STATS_EN
        if (e.chk_st) begin
          check("br_total", br_total, e.tot);
          check("br_miss", br_miss, e.mis);
        end
`endif
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic step(input logic pv, input logic pt, input logic [31:0] alt,
                      input logic rv, input logic rt, input logic rn,
                      input logic [2:0] eres, input logic efl,
                      input logic ecp, input logic [31:0] epc,
                      input int unsigned eout, input logic erdy);
    exp_t e;
    @(negedge clk);
    rst         = rn;
    pred_valid  = pv;
    pred_taken  = pt;
    pred_alt_pc = alt;
    res_valid   = rv;
    res_taken   = rt;
    e.cyc      = mon_cyc + 1;
    e.chk_main = 1'b1;
    e.res      = eres;
    e.fl       = efl;
    e.chk_pc   = ecp;
    e.pc       = epc;
    e.outst    = eout;
    e.rdy      = erdy;
    e.chk_st   = 1'b0;
    e.tot      = 0;
    e.mis      = 0;
    sb.push_back(e);
  endtask

  // Queue a counter expectation for the same sample point as the last step.
  task automatic st_exp(input int unsigned tot, input int unsigned mis);
    exp_t e;
    e.cyc      = mon_cyc + 1;
    e.chk_main = 1'b0;
    e.res      = '0;
    e.fl       = 1'b0;
    e.chk_pc   = 1'b0;
    e.pc       = '0;
    e.outst    = 0;
    e.rdy      = 1'b0;
    e.chk_st   = 1'b1;
    e.tot      = tot;
    e.mis      = mis;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0; pred_alt_pc = '0;
    res_valid = 1'b0; res_taken = 1'b0;

    // Reset state
    step(0,0,32'h0,   0,0,0, 3'b000,0,1,32'h0,   0,1);
    step(0,0,32'h0,   0,0,0, 3'b000,0,1,32'h0,   0,1);

    // Hit path
    step(1,1,32'h100, 0,0,1, 3'b000,0,1,32'h0,   1,1);
    step(0,0,32'h0,   1,1,1, 3'b111,0,1,32'h0,   0,1);
    step(0,0,32'h0,   0,0,1, 3'b000,0,1,32'h0,   0,1);

    // Miss with younger-entry discard
    step(1,0,32'h200, 0,0,1, 3'b000,0,1,32'h0,   1,1);
    step(1,1,32'h300, 0,0,1, 3'b000,0,1,32'h0,   2,1);
    step(1,1,32'h400, 0,0,1, 3'b000,0,1,32'h0,   3,1);
    step(0,0,32'h0,   1,1,1, 3'b110,1,1,32'h200, 0,1);
    step(0,0,32'h0,   0,0,1, 3'b000,0,1,32'h200, 0,1);

    // Miss discards a same-cycle enqueue
    step(1,1,32'h500, 0,0,1, 3'b000,0,1,32'h200, 1,1);
    step(1,0,32'h600, 1,0,1, 3'b100,1,1,32'h500, 0,1);
    step(0,0,32'h0,   0,0,1, 3'b000,0,1,32'h500, 0,1);

    // Resolve on empty queue
    step(0,0,32'h0,   1,1,1, 3'b000,0,1,32'h500, 0,1);

    // Full queue: 5th prediction dropped alongside a hit resolve
    step(1,1,32'h10,  0,0,1, 3'b000,0,1,32'h500, 1,1);
    step(1,0,32'h20,  0,0,1, 3'b000,0,1,32'h500, 2,1);
    step(1,1,32'h30,  0,0,1, 3'b000,0,1,32'h500, 3,1);
    step(1,0,32'h40,  0,0,1, 3'b000,0,1,32'h500, 4,0);
    step(1,0,32'h50,  1,1,1, 3'b111,0,1,32'h500, 3,1);
    step(0,0,32'h0,   1,0,1, 3'b101,0,1,32'h500, 2,1);
    step(0,0,32'h0,   1,1,1, 3'b111,0,1,32'h500, 1,1);
    step(0,0,32'h0,   1,0,1, 3'b101,0,1,32'h500, 0,1);

    // Hit with simultaneous enqueue keeps occupancy and order
    step(1,1,32'h60,  0,0,1, 3'b000,0,1,32'h500, 1,1);
    step(1,0,32'h70,  1,1,1, 3'b111,0,1,32'h500, 1,1);
    step(0,0,32'h0,   1,1,1, 3'b110,1,1,32'h70,  0,1);
    st_exp(9, 3);

    // Mid-operation reset with a resolve and enqueue pending
    step(1,1,32'h80,  0,0,1, 3'b000,0,1,32'h70,  1,1);
    step(1,0,32'h90,  0,0,1, 3'b000,0,1,32'h70,  2,1);
    step(1,1,32'hA0,  0,0,1, 3'b000,0,1,32'h70,  3,1);
    step(1,1,32'hB0,  1,0,0, 3'b000,0,1,32'h0,   0,1);
    st_exp(0, 0);
    step(0,0,32'h0,   0,0,1, 3'b000,0,1,32'h0,   0,1);

    // Five resolutions, two misses
    step(1,1,32'hC0,  0,0,1, 3'b000,0,1,32'h0,   1,1);
    step(0,0,32'h0,   1,1,1, 3'b111,0,1,32'h0,   0,1);
    step(1,0,32'hD0,  0,0,1, 3'b000,0,1,32'h0,   1,1);
    step(0,0,32'h0,   1,0,1, 3'b101,0,1,32'h0,   0,1);
    step(1,1,32'hE0,  0,0,1, 3'b000,0,1,32'h0,   1,1);
    step(0,0,32'h0,   1,0,1, 3'b100,1,1,32'hE0,  0,1);
    step(1,0,32'hF0,  0,0,1, 3'b000,0,1,32'hE0,  1,1);
    step(0,0,32'h0,   1,0,1, 3'b101,0,1,32'hE0,  0,1);
    step(1,1,32'h110, 0,0,1, 3'b000,0,1,32'hE0,  1,1);
    step(0,0,32'h0,   1,0,1, 3'b100,1,1,32'h110, 0,1);
    st_exp(5, 2);
    step(0,0,32'h0,   0,0,0, 3'b000,0,1,32'h0,   0,1);
    st_exp(0, 0);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
